// File: rtl/dma_rd_ctrl.sv
// Read-side DMA controller: issues word reads, forwards responses into the
// downstream FIFO and only issues when the FIFO can absorb every response in flight.
module dma_rd_ctrl #(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int SIZE_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 512,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go,
  input  logic [ADDR_WIDTH-1:0]         start_addr,
  input  logic [SIZE_WIDTH-1:0]         size,
  output logic                          done,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_en,
  input  logic                          rd_ready,
  input  logic                          rsp_valid,
  input  logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_space,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data
);

  localparam int SPACE_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FLIGHT_W = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [SIZE_WIDTH-1:0] req_remaining;
  logic [SIZE_WIDTH-1:0] rsp_remaining;
  logic [SIZE_WIDTH-1:0] req_next;
  logic [SIZE_WIDTH-1:0] rsp_next;
  logic [FLIGHT_W-1:0]   in_flight;
  logic [FLIGHT_W-1:0]   in_flight_next;
  logic                  credit_ok;
  logic                  accept;
  logic                  rsp_take;
  logic                  start;

  // Responses go straight through so in_flight and the FIFO space move on the same edge.
  assign fifo_wr_en   = rsp_valid;
  assign fifo_wr_data = rsp_data;

  assign credit_ok = (SPACE_W'(in_flight) < fifo_space) &&
                     (in_flight < FLIGHT_W'(MAX_OUTSTANDING));
  assign rd_en     = (state == ISSUE) && (req_remaining != '0) && credit_ok;
  assign accept    = rd_en && rd_ready;
  assign rsp_take  = rsp_valid && (rsp_remaining != '0);
  assign start     = go && ((state == IDLE) || (state == DONE));
  assign req_next  = req_remaining - SIZE_WIDTH'(accept);
  assign rsp_next  = rsp_remaining - SIZE_WIDTH'(rsp_take);
  assign done      = (state == DONE);

  always_comb begin
    in_flight_next = in_flight;
    if (accept && !rsp_valid) begin
      in_flight_next = in_flight + FLIGHT_W'(1);
    end else if (!accept && rsp_valid && (in_flight != '0)) begin
      in_flight_next = in_flight - FLIGHT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_next = (size == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (req_next == '0) begin
          state_next = (rsp_next == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (rsp_next == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      req_remaining <= '0;
      rsp_remaining <= '0;
      in_flight     <= '0;
    end else begin
      state     <= state_next;
      in_flight <= in_flight_next;
      if (start) begin
        rd_addr       <= start_addr;
        req_remaining <= size;
        rsp_remaining <= size;
      end else begin
        if (accept) begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
        end
        req_remaining <= req_next;
        rsp_remaining <= rsp_next;
      end
    end
  end

endmodule

// File: doc/dma_rd_ctrl.md
Name: dma_rd_ctrl

Overview:
- Read-side DMA controller; sits directly upstream of the DMA read-data FIFO.
- Issues one word-address read request per word of a transfer to the memory read port.
- Forwards each read response straight into the FIFO write port.
- Uses the FIFO's space output as a credit source, so responses already in flight can never overflow the FIFO.
- Asserts done when every requested word has been written into the FIFO.

Parameters:
- ADDR_WIDTH, 48: word-address width of memory read port.
- DATA_WIDTH, 512: width of read data and of FIFO write data.
- SIZE_WIDTH, 32: width of transfer length in words.
- FIFO_DEPTH, 512: depth of downstream FIFO; space input width is $clog2(FIFO_DEPTH)+1.
- MAX_OUTSTANDING, 64: maximum issued-but-unreturned requests; power of two, at most FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- go  in  1  start pulse; sampled only in IDLE or DONE
- start_addr  in  ADDR_WIDTH  first word address; captured on accepted go
- size  in  SIZE_WIDTH  number of words; captured on accepted go
- done  out  1  transfer complete; held until next accepted go
- rd_addr  out  ADDR_WIDTH  memory read address
- rd_en  out  1  request valid
- rd_ready  in  1  memory accepts request; a request transfers when rd_en && rd_ready
- rsp_valid  in  1  read response valid; responses return in order, cannot be stalled
- rsp_data  in  DATA_WIDTH  read response data
- fifo_space  in  $clog2(FIFO_DEPTH)+1  registered space output of FIFO
- fifo_wr_en  out  1  FIFO write enable
- fifo_wr_data  out  DATA_WIDTH  FIFO write data

Interface description:
- One clock, clk. Reset is synchronous and active-low, port rst: all state clears on a rising edge of clk while rst==0.

Behaviour:
Reset values:
- State IDLE; done=0, rd_en=0, rd_addr=0, fifo_wr_en=0.
- Internal counters: req_remaining=0, rsp_remaining=0, in_flight=0.

Response forwarding:
- fifo_wr_en = rsp_valid and fifo_wr_data = rsp_data, combinational with zero latency.
- Zero latency is required so that in_flight and fifo_space update on the same edge.

Credit rule:
- rd_en=1 only in ISSUE when req_remaining>0, in_flight < fifo_space and in_flight < MAX_OUTSTANDING.
- The compare uses registered in_flight; no combinational path from rd_ready or rsp_valid to rd_en.
- rd_en may drop without an accepted request (credit loss); rd_addr holds while rd_en=1 && rd_ready=0.

Counters (all update at clock edge):
- On request accept: rd_addr+=1, req_remaining-=1.
- in_flight += (accept) - (rsp_valid), so simultaneous accept and response leaves it unchanged.
- On rsp_valid: rsp_remaining-=1.
- rd_addr wraps modulo 2^ADDR_WIDTH with no error.

State machine:
- IDLE: on go, capture start_addr into rd_addr; req_remaining=rsp_remaining=size; go to ISSUE, or directly to DONE if size==0.
- ISSUE: issue requests under the credit rule. When req_remaining reaches 0, go to DRAIN, or to DONE if rsp_remaining also reaches 0 that cycle.
- DRAIN: rd_en=0; go to DONE on the cycle rsp_remaining reaches 0.
- DONE: done=1. On go, behave as IDLE and clear done on the same edge.

Other rules:
- go in ISSUE or DRAIN is ignored; inputs are not recaptured.
- Latency: with rd_ready=1 and full credit, the first rd_en is the cycle after go is sampled, then one request per cycle.
- done rises on the edge after the last rsp_valid (or the edge after go when size==0).
- rsp_valid with rsp_remaining==0 (protocol violation): still forwarded to the FIFO; counters saturate at 0; flagged by a bench assertion.
- fifo_space==0: no requests issued; in-flight responses are still written. The credit rule guarantees these never exceed the space present at issue time.
- Reset mid-transfer returns to IDLE in one cycle. In-flight responses arriving after reset are forwarded; that is the system's responsibility, not this block's.

Test Plan:
- Basic transfer: start_addr=0x100, size=8, rd_ready=1, fixed 3-cycle response latency, space=512. Requires rd_en high 8 consecutive cycles at addresses 0x100..0x107, 8 FIFO writes in order, done=1 one cycle after the 8th response.
- Zero length: size=0, go -> done=1 next cycle, no rd_en and no fifo_wr_en ever asserted.
- Credit limit: fifo_space held at 4, FIFO never read, responses withheld, size=16. Requires exactly 4 accepts, then rd_en=0. Release responses and raise space to 16: remaining 12 issued, and in_flight+occupancy ≤ 16 at every cycle.
- Backpressure and outstanding cap: MAX_OUTSTANDING=64, responses withheld, random rd_ready, size=100. Requires rd_addr stable while rd_en && !rd_ready, in_flight peaks at 64, all 100 words are delivered in order, and done asserts.
- Wrap and restart: start_addr=2^ADDR_WIDTH-2, size=4 -> addresses max-1, max, 0, 1. go pulsed mid-transfer is ignored. A second go in DONE clears done and starts a new transfer.
- Reset mid-transfer: rst=0 for one cycle during ISSUE of a size=32 transfer -> the next cycle shows state IDLE, rd_en=0, done=0, rd_addr=0. A new go then completes normally.
